// File: rtl/memory_game_engine_if.sv
// Handshake and display bundle between the board I/O layer and the memory game round engine.
// The master modport belongs to the I/O side, the slave modport to the engine.
interface memory_game_engine_if #(
    parameter int unsigned WIDTH = 10
);
    logic             start;
    logic             submit;
    logic [WIDTH-1:0] sw;
    logic [WIDTH-1:0] led;
    logic [2:0]       state;
    logic [6:0]       round;
    logic [6:0]       correct;
    logic [6:0]       incorrect;
    logic [6:0]       percent;
    logic             result_valid;
    logic             last_ok;
    logic             done;

    modport master (
        output start, submit, sw,
        input  led, state, round, correct, incorrect, percent, result_valid, last_ok, done
    );

    modport slave (
        input  start, submit, sw,
        output led, state, round, correct, incorrect, percent, result_valid, last_ok, done
    );
endinterface

// File: rtl/memory_game_engine.sv
// Memory game round engine: LFSR pattern, timed show, answer check, tallies and a serial percentage.
// Define MEMORY_GAME_TIMEOUT_EN to add an answer window that forces a wrong answer on expiry.
module memory_game_engine #(
    parameter int unsigned WIDTH          = 10,
    parameter int unsigned ROUNDS         = 20,
    parameter int unsigned SHOW_CYCLES    = 50_000_000,
    parameter logic [15:0] SEED           = 16'hACE1,
    parameter int unsigned TIMEOUT_CYCLES = 250_000_000
) (
    input logic                clock_50M,
    input logic                reset,
    memory_game_engine_if.slave game
);
    typedef enum logic [2:0] {
        StIdle  = 3'd0,
        StGen   = 3'd1,
        StShow  = 3'd2,
        StWait  = 3'd3,
        StCheck = 3'd4,
        StDiv   = 3'd5,
        StDone  = 3'd6
    } state_e;

    state_e           state_q, state_d;
    logic [15:0]      lfsr_q, lfsr_d;
    logic [WIDTH-1:0] pattern_q, pattern_d;
    logic [WIDTH-1:0] answer_q, answer_d;
    logic [WIDTH-1:0] led_q, led_d;
    logic [31:0]      show_cnt_q, show_cnt_d;
    logic [2:0]       div_cnt_q, div_cnt_d;
    logic [6:0]       rem_q, rem_d, dvd_q, dvd_d, quo_q, quo_d, divisor_q, divisor_d;
    logic [6:0]       round_q, round_d, correct_q, correct_d;
    logic [6:0]       incorrect_q, incorrect_d, percent_q, percent_d;
    logic             result_valid_q, result_valid_d;
    logic             last_ok_q, last_ok_d;
    logic             done_q, done_d;
    logic             timeout_hit;
    logic [13:0]      dividend;
    logic [7:0]       trial;
    logic [6:0]       quo_next;

    always_comb begin
        state_d        = state_q;
        lfsr_d         = lfsr_q;
        pattern_d      = pattern_q;
        answer_d       = answer_q;
        show_cnt_d     = show_cnt_q;
        div_cnt_d      = div_cnt_q;
        rem_d          = rem_q;
        dvd_d          = dvd_q;
        quo_d          = quo_q;
        divisor_d      = divisor_q;
        round_d        = round_q;
        correct_d      = correct_q;
        incorrect_d    = incorrect_q;
        percent_d      = percent_q;
        last_ok_d      = last_ok_q;
        result_valid_d = 1'b0;
        dividend       = '0;
        // Restoring step: bring down the next dividend bit, subtract if it fits.
        trial          = {rem_q, dvd_q[6]};
        quo_next       = {quo_q[5:0], (trial >= {1'b0, divisor_q})};

        case (state_q)
            StIdle: begin
                if (game.start) state_d = StGen;
            end
            StGen: begin
                pattern_d  = (lfsr_q[WIDTH-1:0] == '0) ? WIDTH'(1) : lfsr_q[WIDTH-1:0];
                lfsr_d     = lfsr_q[0] ? ((lfsr_q >> 1) ^ 16'hB400) : (lfsr_q >> 1);
                round_d    = round_q + 7'd1;
                show_cnt_d = '0;
                state_d    = StShow;
            end
            StShow: begin
                if (show_cnt_q == 32'(SHOW_CYCLES - 1)) state_d = StWait;
                else show_cnt_d = show_cnt_q + 32'd1;
            end
            StWait: begin
                if (game.submit) begin
                    answer_d = game.sw;
                    state_d  = StCheck;
                end else if (timeout_hit) begin
                    answer_d = ~pattern_q;
                    state_d  = StCheck;
                end
            end
            StCheck: begin
                if (answer_q == pattern_q) begin
                    correct_d = correct_q + 7'd1;
                    last_ok_d = 1'b1;
                end else begin
                    incorrect_d = incorrect_q + 7'd1;
                    last_ok_d   = 1'b0;
                end
                // Quotient is at most 100, so the top 7 dividend bits are already below the divisor.
                dividend  = 14'(correct_d) * 14'd100;
                rem_d     = dividend[13:7];
                dvd_d     = dividend[6:0];
                divisor_d = correct_d + incorrect_d;
                quo_d     = '0;
                div_cnt_d = '0;
                state_d   = StDiv;
            end
            StDiv: begin
                rem_d     = quo_next[0] ? 7'(trial - {1'b0, divisor_q}) : trial[6:0];
                dvd_d     = {dvd_q[5:0], 1'b0};
                quo_d     = quo_next;
                div_cnt_d = div_cnt_q + 3'd1;
                if (div_cnt_q == 3'd6) begin
                    percent_d      = quo_next;
                    result_valid_d = 1'b1;
                    state_d        = (round_q == 7'(ROUNDS)) ? StDone : StGen;
                end
            end
            StDone: begin
                if (game.start) begin
                    round_d     = '0;
                    correct_d   = '0;
                    incorrect_d = '0;
                    percent_d   = '0;
                    last_ok_d   = 1'b0;
                    state_d     = StGen;
                end
            end
            default: state_d = StIdle;
        endcase

        led_d  = (state_d == StShow) ? pattern_d : '0;
        done_d = (state_d == StDone);
    end

    always_ff @(posedge clock_50M) begin
        if (reset) begin
            state_q        <= StIdle;
            lfsr_q         <= SEED;
            pattern_q      <= '0;
            answer_q       <= '0;
            led_q          <= '0;
            show_cnt_q     <= '0;
            div_cnt_q      <= '0;
            rem_q          <= '0;
            dvd_q          <= '0;
            quo_q          <= '0;
            divisor_q      <= '0;
            round_q        <= '0;
            correct_q      <= '0;
            incorrect_q    <= '0;
            percent_q      <= '0;
            result_valid_q <= 1'b0;
            last_ok_q      <= 1'b0;
            done_q         <= 1'b0;
        end else begin
            state_q        <= state_d;
            lfsr_q         <= lfsr_d;
            pattern_q      <= pattern_d;
            answer_q       <= answer_d;
            led_q          <= led_d;
            show_cnt_q     <= show_cnt_d;
            div_cnt_q      <= div_cnt_d;
            rem_q          <= rem_d;
            dvd_q          <= dvd_d;
            quo_q          <= quo_d;
            divisor_q      <= divisor_d;
            round_q        <= round_d;
            correct_q      <= correct_d;
            incorrect_q    <= incorrect_d;
            percent_q      <= percent_d;
            result_valid_q <= result_valid_d;
            last_ok_q      <= last_ok_d;
            done_q         <= done_d;
        end
    end

`ifdef MEMORY_GAME_TIMEOUT_EN
    logic [31:0] to_cnt_q;

    // Loaded on entry to WAIT; the window closes in the cycle the count would reach zero.
    always_ff @(posedge clock_50M) begin
        if (reset) begin
            to_cnt_q <= '0;
        end else if (state_q != StWait && state_d == StWait) begin
            to_cnt_q <= 32'(TIMEOUT_CYCLES);
        end else if (state_q == StWait && to_cnt_q != '0) begin
            to_cnt_q <= to_cnt_q - 32'd1;
        end
    end

    assign timeout_hit = (to_cnt_q == 32'd1);
`else
    assign timeout_hit = 1'b0;

    // Answer window disabled; TIMEOUT_CYCLES stays in the list so both builds share one interface.
    if (TIMEOUT_CYCLES == 0) begin : g_no_timeout_window
    end
`endif

    assign game.led          = led_q;
    assign game.state        = state_q;
    assign game.round        = round_q;
    assign game.correct      = correct_q;
    assign game.incorrect    = incorrect_q;
    assign game.percent      = percent_q;
    assign game.result_valid = result_valid_q;
    assign game.last_ok      = last_ok_q;
    assign game.done         = done_q;
endmodule

// File: tb/tb_memory_game_engine.sv
// Self-checking bench for memory_game_engine: directed table rounds, random games against a
// game-rule model, reset during division and the answer window (both builds of the macro).
module tb_memory_game_engine;
    localparam int unsigned WIDTH          = 10;
    localparam int unsigned ROUNDS         = 2;
    localparam int unsigned SHOW_CYCLES    = 4;
    localparam int unsigned TIMEOUT_CYCLES = 8;
    localparam logic [15:0] SEED           = 16'hACE1;

    typedef struct {
        logic [WIDTH-1:0] sw;
        logic [WIDTH-1:0] pattern;
        int unsigned      round;
        int unsigned      correct;
        int unsigned      incorrect;
        int unsigned      percent;
        bit               last_ok;
        bit               done;
        bit               timeout;
    } row_t;

    logic clock_50M = 1'b0;
    logic reset;
    int   n_pass = 0;
    int   n_total = 0;
    int unsigned model_lfsr;

    always #5 clock_50M = ~clock_50M;

    memory_game_engine_if #(.WIDTH(WIDTH)) game ();

    memory_game_engine #(
        .WIDTH          (WIDTH),
        .ROUNDS         (ROUNDS),
        .SHOW_CYCLES    (SHOW_CYCLES),
        .SEED           (SEED),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) dut (
        .clock_50M (clock_50M),
        .reset     (reset),
        .game      (game)
    );

    task automatic check(input string name, input int unsigned actual, input int unsigned expected);
        n_total++;
        if (actual == expected) n_pass++;
        else $display("FAIL %s: got %0d (0x%0h), want %0d (0x%0h)", name, actual, actual,
                      expected, expected);
    endtask

    task automatic step();
        @(negedge clock_50M);
    endtask

    task automatic pulse_start();
        game.start = 1'b1;
        step();
        game.start = 1'b0;
    endtask

    // Game rule: Galois right-shift LFSR, low lanes as pattern, all-zero pattern replaced by 1.
    function automatic int unsigned model_gen();
        int unsigned pat;
        pat = model_lfsr % (1 << WIDTH);
        if (pat == 0) pat = 1;
        if (model_lfsr % 2 == 1) model_lfsr = (model_lfsr / 2) ^ 32'h0000_B400;
        else model_lfsr = model_lfsr / 2;
        return pat;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_state"}, game.state, 0);
        check({tag, "_led"}, game.led, 0);
        check({tag, "_round"}, game.round, 0);
        check({tag, "_correct"}, game.correct, 0);
        check({tag, "_incorrect"}, game.incorrect, 0);
        check({tag, "_percent"}, game.percent, 0);
        check({tag, "_result_valid"}, game.result_valid, 0);
        check({tag, "_last_ok"}, game.last_ok, 0);
        check({tag, "_done"}, game.done, 0);
    endtask

    task automatic play_round(input row_t r);
        int  n;
        bit  have_result;
        n = 0;
        while (game.state != 3'd2 && n < 20) begin
            step();
            n++;
        end
        check("reach_show", (game.state == 3'd2) ? 1 : 0, 1);
        n = 0;
        while (game.state == 3'd2 && n < 50) begin
            check("led_show", game.led, r.pattern);
            // Stray submit and start mid-SHOW must leave the round untouched.
            if (n == 1) begin
                game.submit = 1'b1;
                game.start  = 1'b1;
            end
            step();
            game.submit = 1'b0;
            game.start  = 1'b0;
            n++;
        end
        check("show_len", n, SHOW_CYCLES);
        check("round_after_gen", game.round, r.round);
        check("state_wait", game.state, 3);
        check("led_wait", game.led, 0);

        have_result = 1'b0;
        if (r.timeout) begin
`ifdef MEMORY_GAME_TIMEOUT_EN
            n = 0;
            while (game.state == 3'd3 && n < 50) begin
                step();
                n++;
            end
            check("timeout_wait_len", n, TIMEOUT_CYCLES);
            n = 0;
            while (!game.result_valid && n < 20) begin
                step();
                n++;
            end
            check("timeout_result_valid", game.result_valid, 1);
            have_result = 1'b1;
`else
            repeat (100) step();
            check("no_timeout_state", game.state, 3);
`endif
        end else begin
            repeat ($urandom_range(0, 3)) step();
            game.sw     = r.sw;
            game.submit = 1'b1;
            step();
            game.submit = 1'b0;
            check("state_check", game.state, 4);
            n = 1;
            while (!game.result_valid && n < 20) begin
                step();
                n++;
            end
            check("result_latency", n, 9);
            have_result = 1'b1;
        end

        if (have_result) begin
            check("correct", game.correct, r.correct);
            check("incorrect", game.incorrect, r.incorrect);
            check("percent", game.percent, r.percent);
            check("last_ok", game.last_ok, r.last_ok);
            check("done", game.done, r.done);
            check("round", game.round, r.round);
            check("state_after_div", game.state, r.done ? 6 : 1);
            check("led_after_div", game.led, 0);
            step();
            check("result_valid_pulse", game.result_valid, 0);
        end
    endtask

    initial begin
        row_t rows[4];
        row_t r;
        int   n;
        int unsigned pat, c, i;
        logic [WIDTH-1:0] sw;

        rows[0] = '{10'h0E1, 10'h0E1, 1, 1, 0, 100, 1'b1, 1'b0, 1'b0};
        rows[1] = '{10'h000, 10'h270, 2, 1, 1, 50, 1'b0, 1'b1, 1'b0};
        rows[2] = '{10'h139, 10'h138, 1, 0, 1, 0, 1'b0, 1'b0, 1'b0};
        rows[3] = '{10'h09C, 10'h09C, 2, 1, 1, 50, 1'b1, 1'b1, 1'b0};

        game.start  = 1'b0;
        game.submit = 1'b0;
        game.sw     = '0;
        reset       = 1'b1;
        step();
        // Reset beats a simultaneous start.
        game.start = 1'b1;
        step();
        game.start = 1'b0;
        reset      = 1'b0;
        check_reset_outputs("reset");
        model_lfsr = SEED;

        for (int k = 0; k < 4; k++) begin
            if (rows[k].round == 1) pulse_start();
            play_round(rows[k]);
            pat = model_gen();
        end

        for (int g = 0; g < 5; g++) begin
            pulse_start();
            c = 0;
            i = 0;
            for (int rd = 1; rd <= ROUNDS; rd++) begin
                pat = model_gen();
                sw  = ($urandom_range(0, 1) == 1) ? WIDTH'(pat) : 10'($urandom_range(0, 1023));
                if (sw == WIDTH'(pat)) c++;
                else i++;
                r = '{sw, WIDTH'(pat), rd, c, i, (100 * c) / (c + i), sw == WIDTH'(pat),
                      rd == ROUNDS, 1'b0};
                play_round(r);
            end
        end

        // Reset in the third DIV cycle discards the division and reseeds the LFSR.
        pulse_start();
        n = 0;
        while (game.state != 3'd3 && n < 30) begin
            step();
            n++;
        end
        check("reach_wait", game.state, 3);
        game.sw     = '0;
        game.submit = 1'b1;
        step();
        game.submit = 1'b0;
        repeat (3) step();
        check("in_div", game.state, 5);
        reset = 1'b1;
        step();
        reset = 1'b0;
        check_reset_outputs("div_reset");

        pulse_start();
        r = '{10'h000, 10'h0E1, 1, 0, 1, 0, 1'b0, 1'b0, 1'b1};
        play_round(r);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/memory_game_engine.md
# memory_game_engine

Parametrised round engine for the memory game: generates a pseudo-random LED pattern, shows it for a fixed time, blanks it, then compares the player's switch setting against it on a submit pulse. Keeps correct/incorrect tallies and a sequentially computed success percentage over a configurable number of rounds. Sits between the board I/O layer (edge-detected keys, switches, LEDs) and the hex display formatter. Generalises the fixed 10-switch game to any lane width, round count and show time, and adds LFSR seeding, a done state and an optional answer timeout.

## Interface
- WIDTH, 10: number of switch/LED lanes, 1..16
- ROUNDS, 20: rounds per game, 1..99
- SHOW_CYCLES, 50_000_000: cycles the pattern is shown, ≥1
- SEED, 16'hACE1: LFSR reset value, nonzero
- TIMEOUT_CYCLES, 250_000_000: answer window, used only with the timeout macro
- clock_50M  in  1  system clock; all logic on its rising edge
- reset  in  1  synchronous, active-high
- start  in  1  one-cycle pulse, begins a game
- submit  in  1  one-cycle pulse, player answer strobe
- sw  in  WIDTH  player answer
- led  out  WIDTH  pattern display
- state  out  3  FSM state code
- round  out  7  rounds started in this game
- correct  out  7  correct answers
- incorrect  out  7  wrong or timed-out answers
- percent  out  7  floor(100*correct/(correct+incorrect)), 0 before the first answer
- result_valid  out  1  one-cycle pulse when percent updates
- last_ok  out  1  result of the most recent answer
- done  out  1  high in DONE

## Operation
- States and codes: IDLE=0, GEN=1, SHOW=2, WAIT=3, CHECK=4, DIV=5, DONE=6.
- LFSR: 16-bit Galois, right shift. If lsb=1, next = (s>>1)^16'hB400; else next = s>>1. It advances only in GEN.
- IDLE: `start` → GEN.
- GEN (1 cycle):
  - pattern ← lfsr[WIDTH-1:0]; if that is 0, pattern ← 1.
  - LFSR advances; round increments.
  - → SHOW.
- SHOW: led=pattern for exactly SHOW_CYCLES cycles, then → WAIT. `submit` is ignored.
- WAIT: led=0. On `submit`, answer ← sw (sampled in the submit cycle) → CHECK.
- CHECK (1 cycle):
  - If answer==pattern: correct++ and last_ok=1.
  - Otherwise: incorrect++ and last_ok=0.
  - → DIV.
- DIV (exactly 7 cycles): restoring divide of correct*100 (14 bits) by correct+incorrect (7 bits). Produces one quotient bit per cycle, MSB first.
  - On the last cycle, percent ← quotient and result_valid=1.
  - Then → DONE if round==ROUNDS, else → GEN.
- DONE: outputs hold. `start` clears round, correct, incorrect, percent and last_ok, then → GEN. The LFSR is not reseeded.
- `start` outside IDLE/DONE is ignored. `submit` outside WAIT is ignored.
- Counters never wrap: ROUNDS ≤ 99 bounds all tallies, so the quotient is ≤ 100.

## Timing
- Reset values:
  - state=IDLE, lfsr=SEED, led=0.
  - round, correct, incorrect, percent = 0.
  - result_valid=0, last_ok=0, done=0.
- Reset in any state, including mid-SHOW or mid-DIV, takes effect at the next edge. Partial division is discarded.
- Reset and start in the same cycle: reset wins.
- All outputs are registered.
- start→GEN: 1 cycle. GEN→SHOW: 1. SHOW length: SHOW_CYCLES. Submit→CHECK: 1. CHECK→DIV: 1.
- result_valid asserts 9 cycles after the submit edge (1 + 1 + 7).
- led is nonzero only while state==SHOW.

## Configuration
- MEMORY_GAME_TIMEOUT_EN defined: a down-counter is loaded with TIMEOUT_CYCLES on entry to WAIT.
  - If it reaches 0 with no submit: answer ← ~pattern (forces a mismatch), then → CHECK.
  - If submit arrives in the same cycle as the expiry: submit wins.
- MEMORY_GAME_TIMEOUT_EN undefined: no counter; WAIT waits indefinitely.

## Test plan
Bench parameters for all scenarios: WIDTH=10, ROUNDS=2, SHOW_CYCLES=4, TIMEOUT_CYCLES=8.
- Reset then start → GEN latches pattern 10'h0E1, led=10'h0E1 for 4 cycles, lfsr=16'hE270.
- In WAIT, sw=10'h0E1 + submit → last_ok=1, correct=1, percent=100, result_valid pulse 9 cycles after submit.
- Round 2: pattern 10'h270; sw=0 + submit → incorrect=1, percent=50, done=1, state=6.
- Submit pulsed during SHOW, and start pulsed mid-game → no counter or state change; led still shows the pattern.
- Reset asserted in cycle 3 of DIV → every output back to its reset value; next start again yields pattern 10'h0E1.
- With MEMORY_GAME_TIMEOUT_EN, no submit for 8 WAIT cycles → incorrect=1, last_ok=0, percent=0. Without the macro → state stays 3 after 100 cycles.
